// File: rtl/linecard_uram_rd_arbiter.sv
// Round-robin arbiter for the shared RX FIFO URAM read port, with burst lock and
// a tag pipeline that returns each read result to the requester that issued it.
module linecard_uram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 72,
  parameter int RD_LATENCY = 3,
  parameter int MAX_BURST  = 16
) (
  input  logic                                 clk,
  input  logic                                 areset_n,
  input  logic [NUM_REQ-1:0]                   req_en,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                   req_last,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 uram_rd_en,
  output logic [ADDR_WIDTH-1:0]                uram_rd_addr,
  input  logic [DATA_WIDTH-1:0]                uram_rd_data,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data
);

  localparam int                TAG_W       = $clog2(NUM_REQ);
  localparam int                CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [TAG_W:0]    NUM_REQ_W   = (TAG_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]  MAX_BURST_W = CNT_W'(MAX_BURST);
  localparam bit                LOCK_EN     = (MAX_BURST > 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t             state;
  logic [TAG_W-1:0]   owner;
  logic [TAG_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic [TAG_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic               grant_last;
  logic [TAG_W:0]     cand;
  logic [TAG_W:0]     rr_inc;
  logic [TAG_W-1:0]   rr_next;
  logic [CNT_W-1:0]   cnt_next;

  logic [TAG_W-1:0]   issue_tag;
  logic [RD_LATENCY:1] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [1:RD_LATENCY];

  // Grant: a locked owner keeps the port even while idle; otherwise rotate from rr_ptr.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (state == ST_LOCKED) begin
      grant_idx = owner;
      grant_any = 1'b1;
    end else begin
      // Walk from the far end so the candidate nearest rr_ptr is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr} + (TAG_W + 1)'(k);
        if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
        if (req_en[cand[TAG_W-1:0]]) begin
          grant_idx = cand[TAG_W-1:0];
          grant_any = 1'b1;
        end
      end
    end
    req_ready            = '0;
    req_ready[grant_idx] = grant_any;
  end

  assign accept     = grant_any & req_en[grant_idx];
  assign grant_last = req_last[grant_idx];
  assign rr_inc     = {1'b0, grant_idx} + 1'b1;
  assign rr_next    = (rr_inc == NUM_REQ_W) ? '0 : rr_inc[TAG_W-1:0];
  assign cnt_next   = burst_cnt + 1'b1;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      rr_ptr <= rr_next;
      case (state)
        ST_IDLE: begin
          if (!grant_last && LOCK_EN) begin
            state     <= ST_LOCKED;
            owner     <= grant_idx;
            burst_cnt <= CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          // Release on the last beat or when the burst budget is used up.
          if (grant_last || cnt_next == MAX_BURST_W) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= cnt_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Issue stage plus tag pipeline; stage k is valid k cycles after uram_rd_en.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: the tag pipeline is reset so reads in flight at reset never produce a response.
      uram_rd_en   <= 1'b0;
      uram_rd_addr <= '0;
      issue_tag    <= '0;
      pipe_vld     <= '0;
      for (int k = 1; k <= RD_LATENCY; k++) pipe_tag[k] <= '0;
    end else begin
      uram_rd_en <= accept;
      if (accept) begin
        uram_rd_addr <= req_addr[grant_idx];
        issue_tag    <= grant_idx;
      end
      pipe_vld[1] <= uram_rd_en;
      pipe_tag[1] <= issue_tag;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_vld[RD_LATENCY]) rsp_valid[pipe_tag[RD_LATENCY]] = 1'b1;
  end

  assign rsp_data = uram_rd_data;

endmodule
